// File: rtl/bounce_ctrl.sv
// ---------------------------------------------------------------------------
// bounce_ctrl
//
// Step sequencer for a position counter. In autonomous mode it walks the
// position right until the upper-bound flag is seen, dwells for a number of
// step ticks, walks left until the lower-bound flag, dwells, and so on. In
// manual mode the two level-sensitive buttons request single steps at the
// divider rate. Every step command is a registered one-cycle pulse.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   asynchronous active-high reset
//   en         in   block enable; low returns to IDLE
//   auto_mode  in   1 = autonomous bounce, 0 = manual button drive
//   btn_l      in   manual step-left request
//   btn_r      in   manual step-right request
//   x_min      in   position at or below the lower bound
//   x_max      in   position at or above the upper bound
//   rate       in   step period minus one, in clk cycles
//   oper       out  2'b10 increment, 2'b01 decrement, 2'b00 hold
//   dir        out  current travel direction, 1 = right
//   bounce_cnt out  reversals since reset, saturating at 255
//   busy       out  high in any state other than IDLE
//
// States
//   IDLE   | disabled or waiting to (re)enter a mode; divider held at 0
//   MOVE_R | autonomous travel towards the upper bound
//   MOVE_L | autonomous travel towards the lower bound
//   PAUSE  | dwell at a bound before travelling the other way
//   MANUAL | steps driven by btn_l / btn_r
// ---------------------------------------------------------------------------
module bounce_ctrl #(
    parameter int TICK_W      = 16,
    parameter int PAUSE_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              auto_mode,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              x_min,
    input  logic              x_max,
    input  logic [TICK_W-1:0] rate,
    output logic [1:0]        oper,
    output logic              dir,
    output logic [7:0]        bounce_cnt,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE_R = 3'd1,
        MOVE_L = 3'd2,
        PAUSE  = 3'd3,
        MANUAL = 3'd4
    } state_t;

    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b00;

    // A dwell of 0 or 1 ticks both leave on the first tick seen in PAUSE.
    localparam int PC_LAST = (PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0;
    localparam int PC_W    = (PC_LAST > 0) ? $clog2(PC_LAST + 1) : 1;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [1:0]        oper_q, oper_d;
    logic              dir_q, dir_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic              degenerate;
    logic              mode_bad;
    logic              pause_done;
    logic [7:0]        bcnt_inc;

    // >= rather than == so a rate lowered mid-count still ticks promptly
    // instead of running the divider all the way round.
    assign tick       = (state_q != IDLE) && (cnt_q >= rate);
    assign degenerate = x_min & x_max;
    assign mode_bad   = (state_q == MANUAL) ? auto_mode : ~auto_mode;
    assign pause_done = (pc_q == PC_W'(PC_LAST));
    assign bcnt_inc   = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        oper_d  = OP_HOLD;
        dir_d   = dir_q;
        bcnt_d  = bcnt_q;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            cnt_d = '0;
            if (auto_mode) begin
                // Start towards the lower bound only when unambiguously at the top.
                if (x_max && !x_min) begin
                    state_d = MOVE_L;
                    dir_d   = 1'b0;
                end else begin
                    state_d = MOVE_R;
                    dir_d   = 1'b1;
                end
            end else begin
                state_d = MANUAL;
            end
        end else if (mode_bad) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + TICK_W'(1);
            if (tick) begin
                case (state_q)
                    MOVE_R: begin
                        if (degenerate) begin
                            oper_d = OP_HOLD;
                        end else if (x_max) begin
                            dir_d   = 1'b0;
                            bcnt_d  = bcnt_inc;
                            pc_d    = '0;
                            state_d = PAUSE;
                        end else begin
                            oper_d = OP_INC;
                        end
                    end
                    MOVE_L: begin
                        if (degenerate) begin
                            oper_d = OP_HOLD;
                        end else if (x_min) begin
                            dir_d   = 1'b1;
                            bcnt_d  = bcnt_inc;
                            pc_d    = '0;
                            state_d = PAUSE;
                        end else begin
                            oper_d = OP_DEC;
                        end
                    end
                    PAUSE: begin
                        if (pause_done) begin
                            state_d = dir_q ? MOVE_R : MOVE_L;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                    MANUAL: begin
                        if (btn_r && !btn_l && !x_max) begin
                            oper_d = OP_INC;
                            dir_d  = 1'b1;
                        end else if (btn_l && !btn_r && !x_min) begin
                            oper_d = OP_DEC;
                            dir_d  = 1'b0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            oper_q  <= OP_HOLD;
            dir_q   <= 1'b1;
            bcnt_q  <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            oper_q  <= oper_d;
            dir_q   <= dir_d;
            bcnt_q  <= bcnt_d;
            busy_q  <= busy_d;
        end
    end

    assign oper       = oper_q;
    assign dir        = dir_q;
    assign bounce_cnt = bcnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bounce_ctrl
//
// Directed bench for bounce_ctrl with PAUSE_TICKS = 4. A table of per-cycle
// vectors walks the main state transitions at rate = 0; hand-written
// sequences cover divider timing, degenerate bounds, manual stepping,
// counter saturation and reset in the middle of a dwell.
// ---------------------------------------------------------------------------
module tb_bounce_ctrl;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          auto_mode;
    logic          btn_l;
    logic          btn_r;
    logic          x_min;
    logic          x_max;
    logic [TW-1:0] rate;
    logic [1:0]    oper;
    logic          dir;
    logic [7:0]    bounce_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    bounce_ctrl #(.TICK_W(TW), .PAUSE_TICKS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .auto_mode  (auto_mode),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .x_min      (x_min),
        .x_max      (x_max),
        .rate       (rate),
        .oper       (oper),
        .dir        (dir),
        .bounce_cnt (bounce_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       am;
        logic       bl;
        logic       br;
        logic       xmin;
        logic       xmax;
        logic [1:0] oper;
        logic       dir;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt [22];

    function automatic vec_t mk(input logic e, input logic a, input logic l,
                                input logic r, input logic mn, input logic mx,
                                input logic [1:0] op, input logic d,
                                input logic b, input logic [7:0] c);
        vec_t v;
        v.en = e; v.am = a; v.bl = l; v.br = r; v.xmin = mn; v.xmax = mx;
        v.oper = op; v.dir = d; v.busy = b; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b0;
        auto_mode = 1'b1;
        btn_l     = 1'b0;
        btn_r     = 1'b0;
        x_min     = 1'b0;
        x_max     = 1'b0;
        rate      = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int     exp_op;
        int     prev;
        logic   mono_ok;
        logic   reached;

        //           en am bl br mn mx  oper   dir busy cnt
        vt[0]  = mk(0, 1, 0, 0, 0, 0, 2'b00, 1, 0, 8'd0);
        vt[1]  = mk(1, 1, 0, 0, 0, 0, 2'b00, 1, 1, 8'd0);
        vt[2]  = mk(1, 1, 0, 0, 0, 0, 2'b10, 1, 1, 8'd0);
        vt[3]  = mk(1, 1, 0, 0, 0, 0, 2'b10, 1, 1, 8'd0);
        vt[4]  = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 1, 8'd1);
        vt[5]  = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 1, 8'd1);
        vt[6]  = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 1, 8'd1);
        vt[7]  = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 1, 8'd1);
        vt[8]  = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 1, 8'd1);
        vt[9]  = mk(1, 1, 0, 0, 0, 1, 2'b01, 0, 1, 8'd1);
        vt[10] = mk(1, 1, 0, 0, 1, 0, 2'b00, 1, 1, 8'd2);
        vt[11] = mk(1, 0, 0, 0, 1, 0, 2'b00, 1, 0, 8'd2);
        vt[12] = mk(1, 0, 1, 0, 0, 0, 2'b00, 1, 1, 8'd2);
        vt[13] = mk(1, 0, 1, 0, 0, 0, 2'b01, 0, 1, 8'd2);
        vt[14] = mk(1, 0, 1, 1, 0, 0, 2'b00, 0, 1, 8'd2);
        vt[15] = mk(1, 0, 0, 1, 0, 0, 2'b10, 1, 1, 8'd2);
        vt[16] = mk(1, 0, 0, 1, 0, 1, 2'b00, 1, 1, 8'd2);
        vt[17] = mk(0, 0, 0, 1, 0, 1, 2'b00, 1, 0, 8'd2);
        vt[18] = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 1, 8'd2);
        vt[19] = mk(1, 1, 0, 0, 0, 1, 2'b01, 0, 1, 8'd2);
        vt[20] = mk(1, 1, 0, 0, 1, 1, 2'b00, 0, 1, 8'd2);
        vt[21] = mk(1, 1, 0, 0, 1, 0, 2'b00, 1, 1, 8'd3);

        // reset state
        do_reset();
        chk("reset_oper", oper, 0);
        chk("reset_dir", dir, 1);
        chk("reset_cnt", bounce_cnt, 0);
        chk("reset_busy", busy, 0);

        // table: rate = 0, one tick per cycle
        for (int i = 0; i < 22; i++) begin
            en        = vt[i].en;
            auto_mode = vt[i].am;
            btn_l     = vt[i].bl;
            btn_r     = vt[i].br;
            x_min     = vt[i].xmin;
            x_max     = vt[i].xmax;
            step();
            chk($sformatf("vec%0d_oper", i), oper, vt[i].oper);
            chk($sformatf("vec%0d_dir", i), dir, vt[i].dir);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("vec%0d_cnt", i), bounce_cnt, vt[i].cnt);
        end

        // rate = 3: first increment 4 cycles after leaving IDLE, then every 4
        do_reset();
        rate = 16'd3;
        en   = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_op = (k >= 5 && ((k - 5) % 4) == 0) ? 2 : 0;
            chk($sformatf("rate3_k%0d_oper", k), oper, exp_op);
        end

        // degenerate bounds: nothing moves for 100 cycles
        do_reset();
        x_min = 1'b1;
        x_max = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("degen_k%0d_oper", k), oper, 0);
            chk($sformatf("degen_k%0d_cnt", k), bounce_cnt, 0);
        end
        chk("degen_busy", busy, 1);

        // manual, rate = 1
        do_reset();
        rate      = 16'd1;
        auto_mode = 1'b0;
        btn_l     = 1'b1;
        btn_r     = 1'b1;
        en        = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("man_both_k%0d_oper", k), oper, 0);
        end
        btn_r = 1'b0;
        for (int k = 7; k <= 11; k++) begin
            step();
            chk($sformatf("man_left_k%0d_oper", k), oper, (k % 2 == 1) ? 1 : 0);
        end
        chk("man_left_dir", dir, 0);
        x_min = 1'b1;
        for (int k = 12; k <= 16; k++) begin
            step();
            chk($sformatf("man_xmin_k%0d_oper", k), oper, 0);
        end

        // saturation: bounds follow direction so every move tick reverses
        do_reset();
        en = 1'b1;
        step();
        mono_ok = 1'b1;
        prev    = 0;
        for (int k = 0; k < 1400; k++) begin
            x_max = dir;
            x_min = ~dir;
            step();
            if (int'(bounce_cnt) < prev) mono_ok = 1'b0;
            prev = int'(bounce_cnt);
        end
        chk("sat_cnt", bounce_cnt, 255);
        chk("sat_monotonic", mono_ok, 1);

        // reset in the middle of a dwell with bounce_cnt = 7
        do_reset();
        en = 1'b1;
        step();
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            x_max = dir;
            x_min = ~dir;
            step();
            if (bounce_cnt == 8'd7) begin
                reached = 1'b1;
                break;
            end
        end
        chk("pause_reached", reached, 1);
        chk("pause_cnt", bounce_cnt, 7);
        chk("pause_dir", dir, 0);
        chk("pause_busy", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_oper", oper, 0);
        chk("midrst_dir", dir, 1);
        chk("midrst_cnt", bounce_cnt, 0);
        chk("midrst_busy", busy, 0);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
